mult_job_sequencer: RTL and testbench
=====================================

Name: mult_job_sequencer

Overview:
- Front-end and back-end stage wrapped around the shift-add multiplier core (Start/Ready/Done interface).
- Accepts operand pairs on a valid/ready input and buffers them in a small FIFO.
- Issues one job at a time to the core as a single-cycle Start pulse, collects the product on Done, and presents it on a valid/ready output.
- Supervises each job with a timeout so a hung core cannot stall the pipeline.

Parameters:
- L_WORD, 4, operand width; product width is 2*L_WORD.
- FIFO_DEPTH, 4, operand FIFO entries; power of two, at least 2.
- TIMEOUT, 63, maximum cycles from Start to Done before the job is aborted.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  FIFO can accept; equals not-full.
- in_word1  in  L_WORD  multiplicand.
- in_word2  in  L_WORD  multiplier.
- mul_start  out  1  Start to core; one-cycle pulse.
- mul_word1  out  L_WORD  word1 to core.
- mul_word2  out  L_WORD  word2 to core.
- mul_ready  in  1  core Ready.
- mul_done  in  1  core Done.
- mul_product  in  2*L_WORD  core product.
- out_valid  out  1  result held.
- out_ready  in  1  consumer accepts.
- out_product  out  2*L_WORD  result.
- out_timeout  out  1  result is an aborted job; product forced to 0.
- busy  out  1  FSM not in IDLE, or FIFO non-empty.

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO empty, FSM to IDLE.
  - mul_start=0, mul_word1/2=0.
  - out_valid=0, out_product=0, out_timeout=0.
  - in_ready=1, busy=0.
- FIFO:
  - Push when in_valid && in_ready.
  - Pop only on job completion.
  - A simultaneous push and pop when full is not allowed: in_ready stays 0 when full.
  - Pointers wrap modulo FIFO_DEPTH; use an extra pointer bit for full/empty.
- mul_word1/2 are driven from the FIFO head and stay stable from ISSUE until completion.
- FSM states: IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
  - IDLE -> ISSUE when FIFO non-empty && mul_ready==1 && (out_valid==0 || out_ready==1). The output slot is guaranteed free at completion.
  - ISSUE: mul_start=1 for exactly one cycle; go to WAIT_ACK. Start must never be high two consecutive cycles, otherwise the core restarts.
  - WAIT_ACK: wait for mul_ready==0, which the core asserts the cycle after sampling Start; then go to WAIT_DONE. A stale Done from the previous job is ignored here.
  - WAIT_DONE: when mul_ready==1 && mul_done==1:
    - out_product <= mul_product, out_valid <= 1, out_timeout <= 0.
    - Pop FIFO; go to IDLE.
  - Timeout:
    - A counter is cleared in ISSUE and increments in WAIT_ACK/WAIT_DONE.
    - When it reaches TIMEOUT: out_product <= 0, out_timeout <= 1, out_valid <= 1, pop, go to IDLE.
    - If completion and timeout occur in the same cycle, completion wins.
- Output:
  - out_valid clears on out_valid && out_ready, unless a new result loads in the same cycle, in which case it stays 1 with the new data.
- Latency:
  - Push to Start is 2 cycles minimum: FIFO write, then IDLE->ISSUE.
  - Done to out_valid is 1 cycle.
- Core early-exit paths (zero operand, or an operand equal to 1) must complete correctly: Ready drops for 1–2 cycles, then Ready=1 and Done=1.
- No arithmetic is performed here; the product passes through at full 2*L_WORD width.
- Reset mid-job aborts the job and discards FIFO contents. No partial output is produced.

Decomposition:
- Shared package: L_WORD default, the FSM state encoding (2-bit constants IDLE=0, ISSUE=1, WAIT_ACK=2, WAIT_DONE=3), and the TIMEOUT default.
- One sub-module: mult_job_fifo, a parameterised synchronous FIFO with async active-low reset. It exposes push, pop, full, empty, and head data.
- FSM, timeout counter and output register stay in the top module.

Test Plan:
- Push (3,5) with the core model attached, out_ready=1 -> one mul_start pulse; out_valid=1 with out_product=15, out_timeout=0; busy returns to 0.
- Push (0,7), (1,9), (15,15) back-to-back -> results 0, 9, 225 in order; exactly three single-cycle Start pulses; stale Done never captured early.
- Hold out_ready=0 and push 6 pairs -> first result held; in_ready falls after FIFO holds 4; no Start issued while the output is occupied. Release out_ready -> all 5 remaining results delivered in order.
- Core model with mul_ready stuck at 1 and mul_done at 0 -> after 63 cycles in WAIT states, out_valid=1, out_timeout=1, out_product=0; the next job proceeds normally.
- Assert reset low during WAIT_DONE of (6,7) -> all outputs return to reset values immediately. After release, push (2,4) -> out_product=8.

Source files
------------

// File: rtl/mult_job_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// mult_job_sequencer_pkg
// Shared definitions for the multiplier job sequencer: default operand width,
// default FIFO depth, default job timeout and the 2-bit FSM state encoding.
// -----------------------------------------------------------------------------
package mult_job_sequencer_pkg;

    localparam int L_WORD_DEF     = 4;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int TIMEOUT_DEF    = 63;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ISSUE     = 2'd1;
    localparam logic [1:0] ST_WAIT_ACK  = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

endpackage

// File: rtl/mult_job_fifo.sv
// -----------------------------------------------------------------------------
// mult_job_fifo
// Synchronous FIFO holding pending operand pairs.
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous active-low reset (empties the FIFO)
//   push       write push_data (ignored when full)
//   pop        drop the head entry (ignored when empty)
//   push_data  entry to write
//   full       no free entry
//   empty      no stored entry
//   head_data  oldest stored entry
// -----------------------------------------------------------------------------
module mult_job_fifo
    import mult_job_sequencer_pkg::*;
#(
    parameter int W     = 2 * L_WORD_DEF,
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head_data
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    // One extra pointer bit separates full (MSBs differ) from empty (equal).
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: pointers alone define which entries are live.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/mult_job_sequencer.sv
// -----------------------------------------------------------------------------
// mult_job_sequencer
// Buffers operand pairs, issues them one at a time to a shift-add multiplier
// core (Start/Ready/Done), and returns each product on a valid/ready output.
// A per-job timeout aborts a hung core and returns product 0 with out_timeout.
//
// Handshakes: a transfer happens on a rising clock edge where valid && ready.
// The producer holds valid and data stable until that edge; ready may depend
// combinationally only on internal state, never on valid.
//
// Ports:
//   clock, reset        clock; asynchronous active-low reset
//   in_valid/in_ready   operand input handshake, in_ready = FIFO not full
//   in_word1/in_word2   multiplicand / multiplier
//   mul_start           one-cycle Start pulse to the core
//   mul_word1/2         operands to the core, stable from ISSUE to completion
//   mul_ready/mul_done  core status
//   mul_product         core result
//   out_valid/out_ready result handshake
//   out_product         result (0 for an aborted job)
//   out_timeout         result belongs to an aborted job
//   busy                FSM active or jobs pending
//   fsm_state           current FSM state (debug)
// -----------------------------------------------------------------------------
module mult_job_sequencer
    import mult_job_sequencer_pkg::*;
#(
    parameter int L_WORD     = L_WORD_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [L_WORD-1:0]   in_word1,
    input  logic [L_WORD-1:0]   in_word2,
    output logic                mul_start,
    output logic [L_WORD-1:0]   mul_word1,
    output logic [L_WORD-1:0]   mul_word2,
    input  logic                mul_ready,
    input  logic                mul_done,
    input  logic [2*L_WORD-1:0] mul_product,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*L_WORD-1:0] out_product,
    output logic                out_timeout,
    output logic                busy,
    output logic [1:0]          fsm_state
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    logic [1:0]          state;
    logic                fifo_full;
    logic                fifo_empty;
    logic [2*L_WORD-1:0] head;
    logic                launch;
    logic                in_wait;
    logic                job_done;
    logic                job_timeout;
    logic                job_end;
    logic [CW-1:0]       to_cnt;

    mult_job_fifo #(
        .W     (2 * L_WORD),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (in_valid && !fifo_full),
        .pop       (job_end),
        .push_data ({in_word1, in_word2}),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_data (head)
    );

    assign in_ready = !fifo_full;

    // Only launch when the output slot will be free by the time the job ends.
    assign launch      = (state == ST_IDLE) && !fifo_empty && mul_ready
                         && (!out_valid || out_ready);
    assign in_wait     = (state == ST_WAIT_ACK) || (state == ST_WAIT_DONE);
    // Done is only trusted after Ready has dropped, so a stale Done from the
    // previous job cannot complete this one.
    assign job_done    = (state == ST_WAIT_DONE) && mul_ready && mul_done;
    // to_cnt is 0 on the first wait cycle, so this fires on wait cycle TIMEOUT.
    assign job_timeout = in_wait && !job_done && (to_cnt == TO_LAST);
    assign job_end     = job_done || job_timeout;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:      if (launch) state <= ST_ISSUE;
                ST_ISSUE:     state <= ST_WAIT_ACK;
                ST_WAIT_ACK: begin
                    if (job_timeout)     state <= ST_IDLE;
                    else if (!mul_ready) state <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: if (job_end) state <= ST_IDLE;
                default:      state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            to_cnt <= '0;
        end else if (state == ST_ISSUE) begin
            to_cnt <= '0;
        end else if (in_wait) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // A new result may load in the same cycle the old one is consumed.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid   <= 1'b0;
            out_product <= '0;
            out_timeout <= 1'b0;
        end else if (job_end) begin
            out_valid   <= 1'b1;
            out_product <= job_done ? mul_product : '0;
            out_timeout <= !job_done;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Start is decoded from the single-cycle ISSUE state, so it cannot repeat.
    assign mul_start = (state == ST_ISSUE);
    assign mul_word1 = (state != ST_IDLE) ? head[2*L_WORD-1:L_WORD] : '0;
    assign mul_word2 = (state != ST_IDLE) ? head[L_WORD-1:0]        : '0;
    assign busy      = (state != ST_IDLE) || !fifo_empty;
    assign fsm_state = state;

endmodule

// File: tb/tb_mult_job_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mult_job_sequencer
// Bench for mult_job_sequencer with a behavioural shift-add core model.
// -----------------------------------------------------------------------------
module tb_mult_job_sequencer;

  localparam int L = 4;
  localparam int TIMEOUT = 63;

  // clock / reset
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic           in_valid;
  logic           in_ready;
  logic [L-1:0]   in_word1;
  logic [L-1:0]   in_word2;
  logic           mul_start;
  logic [L-1:0]   mul_word1;
  logic [L-1:0]   mul_word2;
  logic           mul_ready;
  logic           mul_done;
  logic [2*L-1:0] mul_product;
  logic           out_valid;
  logic           out_ready;
  logic [2*L-1:0] out_product;
  logic           out_timeout;
  logic           busy;
  logic [1:0]     fsm_state;

  int errors = 0;
  int checks = 0;
  int start_cnt = 0;
  logic prev_start = 1'b0;
  logic [2*L:0] exp_q[$];   // {timeout, product}

  mult_job_sequencer #(.L_WORD(L), .FIFO_DEPTH(4), .TIMEOUT(TIMEOUT)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_word1    (in_word1),
    .in_word2    (in_word2),
    .mul_start   (mul_start),
    .mul_word1   (mul_word1),
    .mul_word2   (mul_word2),
    .mul_ready   (mul_ready),
    .mul_done    (mul_done),
    .mul_product (mul_product),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product),
    .out_timeout (out_timeout),
    .busy        (busy),
    .fsm_state   (fsm_state)
  );

  // core model: Ready drops the cycle after Start, Done+Ready after latency
  logic           stuck;
  logic [2*L-1:0] core_pend;
  int             core_cnt;

  function automatic int core_lat(input logic [L-1:0] a, input logic [L-1:0] b);
    if (a == 0 || b == 0) return 1;
    if (a == 1 || b == 1) return 2;
    return L;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      mul_ready   <= 1'b1;
      mul_done    <= 1'b0;
      mul_product <= '0;
      core_pend   <= '0;
      core_cnt    <= 0;
    end else if (stuck) begin
      mul_ready <= 1'b1;
      mul_done  <= 1'b0;
    end else if (mul_start) begin
      mul_ready <= 1'b0;
      mul_done  <= 1'b0;
      core_pend <= mul_word1 * mul_word2;
      core_cnt  <= core_lat(mul_word1, mul_word2);
    end else if (!mul_ready) begin
      if (core_cnt <= 1) begin
        mul_ready   <= 1'b1;
        mul_done    <= 1'b1;
        mul_product <= core_pend;
      end else begin
        core_cnt <= core_cnt - 1;
      end
    end
  end

  // scoreboard / monitor, sampled mid-cycle after drivers settle
  always @(negedge clock) begin
    logic [2*L:0] e;
    #1;
    if (reset) begin
      if (mul_start) begin
        checks++;
        if (prev_start)
          begin errors++; $display("FAIL start_pulse: start high two cycles at %0t", $time); end
        start_cnt++;
      end
      prev_start = mul_start;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got timeout=%0b product=%0d, none expected", out_timeout, out_product);
        end else begin
          e = exp_q.pop_front();
          if ({out_timeout, out_product} !== e) begin
            errors++;
            $display("FAIL sb_result: got timeout=%0b product=%0d, want timeout=%0b product=%0d",
                     out_timeout, out_product, e[2*L], e[2*L-1:0]);
          end
        end
      end
    end else begin
      prev_start = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks: called at a falling edge, return at a falling edge
  task automatic send(input logic [L-1:0] a, input logic [L-1:0] b, input logic [2*L:0] e);
    int t = 0;
    in_valid = 1'b1;
    in_word1 = a;
    in_word2 = b;
    while (!in_ready && t < 300) begin @(negedge clock); t++; end
    checks++;
    if (t >= 300) begin
      errors++;
      $display("FAIL send_wait: in_ready stayed %0b for %0d cycles, want 1", in_ready, t);
    end else begin
      exp_q.push_back(e);
    end
    @(negedge clock);
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while ((exp_q.size() != 0 || busy || out_valid) && t < 500) begin
      @(negedge clock); #1; t++;
    end
    checks++;
    if (t >= 500) begin
      errors++;
      $display("FAIL %s_drain: busy=%0b out_valid=%0b pending=%0d, want all idle", name, busy, out_valid, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    checks++;
    if ({mul_start, mul_word1, mul_word2, out_valid, out_product, out_timeout, in_ready, busy, fsm_state}
        !== {1'b0, 4'd0, 4'd0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL reset_values: start=%0b w1=%0d w2=%0d ov=%0b prod=%0d to=%0b ir=%0b busy=%0b st=%0d, want 0 0 0 0 0 0 1 0 0",
               mul_start, mul_word1, mul_word2, out_valid, out_product, out_timeout, in_ready, busy, fsm_state);
    end
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_single();
    int t = 0;
    int s0 = start_cnt;
    send(3, 5, {1'b0, 8'd15});
    in_valid = 1'b0;
    #1;
    checks++;
    if (mul_start !== 1'b0) begin errors++; $display("FAIL single_start_early: got %0b want 0", mul_start); end
    @(negedge clock); #1;
    checks++;
    if (mul_start !== 1'b1) begin errors++; $display("FAIL single_start_latency: got %0b want 1", mul_start); end
    while (!out_valid && t < 50) begin @(negedge clock); #1; t++; end
    checks++;
    if ({out_valid, out_timeout, out_product} !== {1'b1, 1'b0, 8'd15}) begin
      errors++;
      $display("FAIL single_result: got ov=%0b to=%0b prod=%0d want 1 0 15", out_valid, out_timeout, out_product);
    end
    wait_idle("single");
    checks++;
    if (busy !== 1'b0 || start_cnt - s0 != 1) begin
      errors++;
      $display("FAIL single_busy_starts: got busy=%0b starts=%0d want 0 1", busy, start_cnt - s0);
    end
  endtask

  task automatic test_back_to_back();
    int s0 = start_cnt;
    @(negedge clock);
    send(0, 7, {1'b0, 8'd0});
    send(1, 9, {1'b0, 8'd9});
    send(15, 15, {1'b0, 8'd225});
    in_valid = 1'b0;
    wait_idle("b2b");
    checks++;
    if (start_cnt - s0 != 3) begin
      errors++; $display("FAIL b2b_starts: got %0d want 3", start_cnt - s0);
    end
  endtask

  task automatic test_backpressure();
    int s0;
    logic [L-1:0] a;
    logic [L-1:0] b;
    logic [2*L-1:0] p;
    @(negedge clock);
    out_ready = 1'b0;
    s0 = start_cnt;
    for (int i = 0; i < 5; i++) begin
      a = L'($urandom_range(0, 15));
      b = L'($urandom_range(0, 15));
      p = a * b;
      send(a, b, {1'b0, p});
    end
    in_valid = 1'b0;
    repeat (20) @(negedge clock);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %0b want 0", in_ready); end
    checks++;
    if (out_valid !== 1'b1 || {out_timeout, out_product} !== exp_q[0]) begin
      errors++;
      $display("FAIL bp_held: got ov=%0b to=%0b prod=%0d want 1 %0b %0d",
               out_valid, out_timeout, out_product, exp_q[0][2*L], exp_q[0][2*L-1:0]);
    end
    checks++;
    if (start_cnt - s0 != 1 || busy !== 1'b1) begin
      errors++; $display("FAIL bp_starts: got starts=%0d busy=%0b want 1 1", start_cnt - s0, busy);
    end
    @(negedge clock);
    out_ready = 1'b1;
    a = L'($urandom_range(2, 15));
    b = L'($urandom_range(2, 15));
    p = a * b;
    send(a, b, {1'b0, p});
    in_valid = 1'b0;
    wait_idle("bp");
    checks++;
    if (start_cnt - s0 != 6) begin errors++; $display("FAIL bp_total_starts: got %0d want 6", start_cnt - s0); end
  endtask

  task automatic test_timeout();
    int t = 0;
    @(negedge clock);
    stuck = 1'b1;
    send(5, 6, {1'b1, 8'd0});
    in_valid = 1'b0;
    #1;
    while (!mul_start && t < 20) begin @(negedge clock); #1; t++; end
    t = 0;
    while (!out_valid && t < 200) begin @(negedge clock); #1; t++; end
    checks++;
    if (t != TIMEOUT + 1 || out_timeout !== 1'b1 || out_product !== 8'd0) begin
      errors++;
      $display("FAIL timeout_abort: got cycles=%0d to=%0b prod=%0d want %0d 1 0", t, out_timeout, out_product, TIMEOUT + 1);
    end
    @(negedge clock);
    stuck = 1'b0;
    @(negedge clock);
    send(2, 3, {1'b0, 8'd6});
    in_valid = 1'b0;
    wait_idle("timeout");
  endtask

  task automatic test_reset_mid_job();
    int t = 0;
    @(negedge clock);
    send(6, 7, {1'b0, 8'd42});
    in_valid = 1'b0;
    #1;
    while (fsm_state !== 2'd3 && t < 20) begin @(negedge clock); #1; t++; end
    checks++;
    if (t >= 20) begin errors++; $display("FAIL rst_reach_wait_done: got state=%0d want 3", fsm_state); end
    reset = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if ({mul_start, mul_word1, mul_word2, out_valid, out_product, out_timeout, in_ready, busy, fsm_state}
        !== {1'b0, 4'd0, 4'd0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL rst_mid_values: start=%0b w1=%0d w2=%0d ov=%0b prod=%0d to=%0b ir=%0b busy=%0b st=%0d, want 0 0 0 0 0 0 1 0 0",
               mul_start, mul_word1, mul_word2, out_valid, out_product, out_timeout, in_ready, busy, fsm_state);
    end
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    send(2, 4, {1'b0, 8'd8});
    in_valid = 1'b0;
    wait_idle("rst_mid");
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_word1  = '0;
    in_word2  = '0;
    out_ready = 1'b1;
    stuck     = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_timeout();
    test_reset_mid_job();
    repeat (3) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL final_queue: got %0d pending results want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
